// File: rtl/uart_burst_gen.sv
// uart_burst_gen: triggered burst of stored bytes, optionally CR/LF terminated, paced by UART TX busy.
module uart_burst_gen #(
  parameter int PERIOD = 50_000_000,
  parameter int LEN_W = 8,
  parameter int TERM_MODE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [LEN_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  input  logic             tx_busy,
  output logic [7:0]       write_data,
  output logic             write_en,
  output logic             busy,
  output logic             done,
  output logic             drop
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [LEN_W:0] NTAIL = (LEN_W+1)'(TERM_MODE == 2 ? 2 : TERM_MODE == 1 ? 1 : 0);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [LEN_W:0] idx, total, total_in, tail;
  logic [LEN_W-1:0] len_q;
  logic tx_busy_d, tick, trig, fall, last, accept;
  assign tick = cnt == CW'(PERIOD - 1);
  assign trig = mode ? start : tick;
  assign total_in = {1'b0, burst_len} + NTAIL;
  assign accept = state == IDLE && trig && total_in != '0;
  assign fall = tx_busy_d & ~tx_busy;
  assign last = idx == total - (LEN_W+1)'(1);
  assign tail = idx - {1'b0, len_q};
  assign rd_addr = idx[LEN_W-1:0];
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = accept ? FETCH : IDLE;
      FETCH: state_n = SEND;
      SEND:  state_n = WAIT;
      WAIT:  state_n = fall ? (last ? IDLE : FETCH) : WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      total <= '0;
      len_q <= '0;
      tx_busy_d <= 1'b0;
      write_data <= '0;
      write_en <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      tx_busy_d <= tx_busy;
      write_en <= state == SEND;
      done <= state == WAIT && fall && last;
      drop <= trig && state != IDLE;
      if (accept) begin
        idx <= '0;
        total <= total_in;
        len_q <= burst_len;
      end
      if (state == WAIT && fall && !last) idx <= idx + (LEN_W+1)'(1);
      // past the payload, idx selects the terminator byte and rd_data is ignored
      if (state == SEND)
        write_data <= idx < {1'b0, len_q} ? rd_data : (TERM_MODE == 2 && tail == '0 ? 8'h0D : 8'h0A);
    end
endmodule

// File: tb/tb_uart_burst_gen.sv
// tb_uart_burst_gen: three DUTs (TERM_MODE 0,1,2) share stimulus; byte scoreboard per DUT plus directed timing checks.
module tb_uart_burst_gen;
  localparam int P = 64;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b1, start = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic [7:0] rd_addr [3];
  logic [7:0] write_data [3];
  logic [2:0] tx_busy, write_en, busy, done, drop, prev_we;
  logic [7:0] mem [256];
  logic [7:0] exp_q [3][$];
  int we_cnt [3], done_cnt [3], drop_cnt [3];
  int we_log [$];
  int cyc = 0, rel = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] rdq;
    logic [3:0] bcnt;
    uart_burst_gen #(.PERIOD(P), .LEN_W(8), .TERM_MODE(g)) u_dut (
      .clk(clk), .rst(rst), .mode(mode), .start(start), .burst_len(burst_len),
      .rd_addr(rd_addr[g]), .rd_data(rdq), .tx_busy(tx_busy[g]),
      .write_data(write_data[g]), .write_en(write_en[g]), .busy(busy[g]),
      .done(done[g]), .drop(drop[g])
    );
    always_ff @(posedge clk) rdq <= mem[rd_addr[g]];
    // UART model: busy from the cycle after write_en for 10 cycles
    always_ff @(posedge clk or posedge rst)
      if (rst) bcnt <= '0;
      else if (write_en[g]) bcnt <= 4'd10;
      else if (bcnt != 0) bcnt <= bcnt - 4'd1;
    assign tx_busy[g] = bcnt != 0;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_burst(input int len);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < len; i++) exp_q[g].push_back(8'(8'h41 + i));
      if (g == 2) exp_q[g].push_back(8'h0D);
      if (g != 0) exp_q[g].push_back(8'h0A);
    end
  endtask
  task automatic clear;
    for (int g = 0; g < 3; g++) begin
      exp_q[g].delete();
      we_cnt[g] = 0;
      done_cnt[g] = 0;
      drop_cnt[g] = 0;
    end
    we_log.delete();
  endtask
  task automatic wait_idle;
    int k = 0;
    while (busy !== 3'b0 && k < 3000) begin
      step();
      k++;
    end
    chk("idle_reached", busy, 0);
    step(2);
  endtask
  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic end_checks(input string tag, input int dn0, dn1, dn2, dr);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_q_empty%0d", tag, g), exp_q[g].size(), 0);
      chk($sformatf("%s_done%0d", tag, g), done_cnt[g], g == 0 ? dn0 : g == 1 ? dn1 : dn2);
      chk($sformatf("%s_drop%0d", tag, g), drop_cnt[g], dr);
    end
  endtask
  task automatic align;
    int k = 0;
    while ((cyc - rel) % P != 1 && k < 200) begin
      step();
      k++;
    end
  endtask
  always @(negedge clk)
    for (int g = 0; g < 3; g++) begin
      if (write_en[g]) begin
        we_cnt[g]++;
        if (g == 2) we_log.push_back(cyc);
        chk($sformatf("we_gap%0d", g), prev_we[g], 0);
        chk($sformatf("we_expected%0d", g), exp_q[g].size() > 0, 1);
        if (exp_q[g].size() > 0) chk($sformatf("data%0d", g), write_data[g], exp_q[g].pop_front());
      end
      prev_we[g] = write_en[g];
      done_cnt[g] += int'(done[g]);
      drop_cnt[g] += int'(drop[g]);
    end
  initial begin
    int k, t0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h41 + i);
    clear();
    step(2);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset_outs%0d", g), {write_data[g], write_en[g], rd_addr[g], busy[g], done[g], drop[g]}, 0);
    rst = 1'b0;
    rel = cyc;
    step(3);
    // one-shot burst of 4 with directed timing on the CR/LF instance
    burst_len = 8'd4;
    push_burst(4);
    pulse_start();
    chk("fetch_addr", rd_addr[2], 0);
    chk("busy_fetch", busy, 3'b111);
    step();
    chk("we_t2", write_en[2], 0);
    step();
    chk("we_t3", write_en[2], 1);
    k = 0;
    while (tx_busy[2] !== 1'b1 && k < 50) begin step(); k++; end
    while (tx_busy[2] !== 1'b0 && k < 50) begin step(); k++; end
    chk("first_fall", k < 50, 1);
    step(2);
    chk("we_f2", write_en[2], 0);
    step();
    chk("we_f3", write_en[2], 1);
    k = 0;
    while (we_cnt[2] < 6 && k < 400) begin step(); k++; end
    while (tx_busy[2] !== 1'b0 && k < 400) begin step(); k++; end
    chk("last_fall", k < 400, 1);
    chk("done_f0", done[2], 0);
    step();
    chk("done_f1", done[2], 1);
    chk("busy_f1", busy[2], 0);
    wait_idle();
    end_checks("burst4", 1, 1, 1, 0);
    // zero-length payload: only terminator bytes, nothing at all without one
    clear();
    burst_len = 8'd0;
    push_burst(0);
    pulse_start();
    step(2);
    wait_idle();
    end_checks("len0", 0, 1, 1, 0);
    chk("len0_we0", we_cnt[0], 0);
    chk("len0_we2", we_cnt[2], 2);
    // burst_len changed mid-burst must not affect the running burst
    clear();
    burst_len = 8'd3;
    push_burst(3);
    pulse_start();
    step(5);
    burst_len = 8'd9;
    wait_idle();
    end_checks("lenchg", 1, 1, 1, 0);
    // reset while waiting on the third byte
    clear();
    burst_len = 8'd4;
    push_burst(4);
    pulse_start();
    k = 0;
    while (we_cnt[2] < 3 && k < 200) begin step(); k++; end
    step(2);
    chk("abort_busy_before", busy[2], 1);
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("abort_outs%0d", g), {write_data[g], write_en[g], rd_addr[g], busy[g], done[g], drop[g]}, 0);
    clear();
    step(2);
    rst = 1'b0;
    rel = cyc;
    step(2);
    end_checks("abort", 0, 0, 0, 0);
    push_burst(4);
    pulse_start();
    chk("restart_addr", rd_addr[2], 0);
    wait_idle();
    end_checks("restart", 1, 1, 1, 0);
    // periodic mode, bursts shorter than the period
    clear();
    burst_len = 8'd2;
    align();
    t0 = cyc + P - 1;
    mode = 1'b0;
    for (int i = 0; i < 3; i++) push_burst(2);
    step(3 * P);
    mode = 1'b1;
    wait_idle();
    end_checks("per2", 3, 3, 3, 0);
    chk("per2_start0", we_log[0], t0 + 2);
    chk("per2_start1", we_log[4], t0 + P + 2);
    chk("per2_start2", we_log[8], t0 + 2 * P + 2);
    // periodic mode, bursts longer than the period: ticks while busy are dropped
    clear();
    burst_len = 8'd8;
    align();
    t0 = cyc + P - 1;
    mode = 1'b0;
    for (int i = 0; i < 2; i++) push_burst(8);
    step(4 * P);
    mode = 1'b1;
    wait_idle();
    end_checks("per8", 2, 2, 2, 2);
    chk("per8_start0", we_log[0], t0 + 2);
    chk("per8_start1", we_log[10], t0 + 3 * P + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_burst_gen.md
# uart_burst_gen

Parametrised UART burst source, the successor to the fixed-length UART data generator. On a periodic tick or an external start pulse, it reads `burst_len` payload bytes from a synchronous byte store through `rd_addr`/`rd_data`. It presents each byte to the UART transmitter on `write_data`/`write_en`, pacing on the transmitter's `tx_busy` falling edge, and can append a CR/LF terminator. It sits between the frame/readback buffer and the UART TX core in the debug/telemetry path.

## Interface
- `PERIOD`, 50_000_000: clock cycles between periodic triggers (mode 0); must be ≥ 2.
- `LEN_W`, 8: width of `burst_len` and `rd_addr`.
- `TERM_MODE`, 2: terminator appended after the payload. 0 = none, 1 = 0x0A, 2 = 0x0D then 0x0A.
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `mode` in 1: 0 = periodic trigger every `PERIOD` cycles; 1 = one-shot on `start`.
- `start` in 1: trigger pulse, used in mode 1 only.
- `burst_len` in LEN_W: payload byte count, sampled at trigger.
- `rd_addr` out LEN_W: payload index presented to the byte store.
- `rd_data` in 8: byte-store output, valid exactly 1 cycle after `rd_addr`.
- `tx_busy` in 1: UART TX busy. It must go high the cycle after `write_en` and stay high until the frame ends.
- `write_data` out 8: byte to transmit, held stable until the next `write_en`.
- `write_en` out 1: one-cycle load strobe to the UART TX.
- `busy` out 1: high while a burst is in progress.
- `done` out 1: one-cycle pulse when the last byte's transmission completes.
- `drop` out 1: one-cycle pulse when a trigger is ignored because a burst is already running.

## Operation
- Reset values: `write_data` = 0, `write_en` = 0, `rd_addr` = 0, `busy` = 0, `done` = 0, `drop` = 0. Internal `idx` = 0, period counter = 0, `tx_busy_d` = 0, state = IDLE.
- Period counter:
  - Free-runs 0..PERIOD-1 and wraps, in both modes.
  - `tick` is asserted when the count equals PERIOD-1.
- Trigger definition:
  - `trig = (mode==0 & tick) | (mode==1 & start)`.
  - A trigger outside IDLE is ignored and pulses `drop` the next cycle.
- `ntail` = number of terminator bytes: 0, 1 or 2 according to `TERM_MODE`.
- `total = burst_len + ntail`, computed LEN_W+1 bits wide and latched at trigger. Later changes to `burst_len` do not affect a running burst.
- States:
  - IDLE: on `trig` with total ≠ 0, latch total, set `idx` = 0, go to FETCH. A trigger with total = 0 is a no-op, with no `drop` and no `done`.
  - FETCH: `rd_addr = idx[LEN_W-1:0]`. Unconditionally go to SEND next cycle.
  - SEND: register `write_data` and pulse `write_en`, then go to WAIT.
    - If `idx < burst_len_latched`, the byte is `rd_data`.
    - Otherwise it is terminator byte `idx - burst_len_latched` (0x0D/0x0A per `TERM_MODE`).
  - WAIT: wait for the falling edge `tx_busy_d & ~tx_busy`.
    - If `idx == total-1`, pulse `done` and go to IDLE.
    - Otherwise increment `idx` and go to FETCH.
- `rd_addr` follows `idx` in every state. During terminator bytes it carries truncated `idx` and `rd_data` is ignored.
- `busy` is high in FETCH, SEND and WAIT.
- Mid-burst reset aborts immediately: `write_en` is low, state is IDLE, and no `done` is issued.

## Timing
- Trigger sampled in IDLE at cycle t:
  - FETCH at t+1, with `rd_addr` = 0 valid.
  - `rd_data` valid at t+2 (SEND).
  - `write_en` high and `write_data` valid at t+3.
- Falling edge of `tx_busy` detected at cycle f (`tx_busy` high at f-1, low at f):
  - Next `write_en` at f+3.
  - For the last byte, `done` at f+1 and `busy` low at f+1.
- A trigger can be accepted in the same cycle `busy` drops. A trigger coincident with the `done` cycle is accepted.
- `write_en` is never high on two consecutive cycles.
- Only falling edges seen in WAIT count.
- `drop` is one cycle wide, one cycle after the ignored trigger.

## Test plan
- Mode 1, `burst_len` = 4, `TERM_MODE` = 2, store holds 0x41..0x44, TX model busy 10 cycles per byte:
  - Expect `write_data` sequence 41 42 43 44 0D 0A.
  - Expect `write_en` at start+3 and 3 cycles after each busy fall.
  - Expect a single `done`.
- Mode 0, `PERIOD` = 200, `burst_len` = 2, `TERM_MODE` = 0: expect a burst starting every 200 cycles and `rd_addr` sequence 0,1 per burst.
- Mode 0, `PERIOD` = 20, `burst_len` = 8:
  - Expect ticks during the burst to produce `drop` pulses with no disturbance of the byte sequence.
  - Expect the next burst only on the first tick after IDLE.
- `burst_len` = 0 with `TERM_MODE` = 0: start produces no `write_en`, no `done`, no `drop`. With `TERM_MODE` = 1, start produces a single 0x0A byte.
- Assert `rst` while in WAIT on the 3rd byte:
  - Expect all outputs at reset values immediately and no `done`.
  - After release, `start` re-sends from `rd_addr` = 0.
- Change `burst_len` from 3 to 9 mid-burst: exactly 3 payload bytes are sent.
